// File: rtl/addr4u_bist_pkg.sv
// Shared types and constants for the addr4u exhaustive adder BIST controller.
package addr4u_bist_pkg;

  localparam int VEC_W = 8;
  localparam int OPW   = 4;
  localparam int SUMW  = 5;
  localparam int NVEC  = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  // Reference sum for a packed {A,B} vector, carry kept.
  function automatic logic [SUMW-1:0] golden_sum(input logic [VEC_W-1:0] vec);
    return {1'b0, vec[VEC_W-1:OPW]} + {1'b0, vec[OPW-1:0]};
  endfunction

endpackage

// File: rtl/addr4u_bist_cmp.sv
// Aligns the golden sum with the adder latency, compares and counts mismatches (saturating).
// ADDR4U_BIST_FAIL_LOG_EN adds a capture of the first failing vector and its sum.
module addr4u_bist_cmp
  import addr4u_bist_pkg::*;
#(
  parameter int LAT   = 0,
  parameter int ERR_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_flush,
  input  logic             i_vld,
  input  logic [VEC_W-1:0] i_vec,
  input  logic [SUMW-1:0]  i_dut_sum,
`ifdef ADDR4U_BIST_FAIL_LOG_EN
  output logic             o_first_fail_vld,
  output logic [VEC_W-1:0] o_first_fail_vec,
  output logic [SUMW-1:0]  o_first_fail_sum,
`endif
  output logic [ERR_W-1:0] o_err_cnt
);

  logic             w_vld_al;
  logic [SUMW-1:0]  w_exp_al;
  logic             w_mis;
  logic [ERR_W-1:0] r_err;
`ifdef ADDR4U_BIST_FAIL_LOG_EN
  logic [VEC_W-1:0] w_vec_al;
`endif

  generate
    if (LAT == 0) begin : g_comb
      logic w_unused_flush;
      assign w_unused_flush = i_flush;
      assign w_vld_al       = i_vld;
      assign w_exp_al       = golden_sum(i_vec);
`ifdef ADDR4U_BIST_FAIL_LOG_EN
      assign w_vec_al       = i_vec;
`endif
    end else begin : g_pipe
      logic [LAT-1:0]  r_vld;
      logic [SUMW-1:0] r_exp [LAT];
`ifdef ADDR4U_BIST_FAIL_LOG_EN
      logic [VEC_W-1:0] r_vec [LAT];
`endif

      // Only the valid tags are reset/flushed; data stages are don't-care when invalid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= '0;
        end else begin
          r_vld[0] <= i_vld & ~i_flush;
          for (int i = 1; i < LAT; i++) r_vld[i] <= r_vld[i-1] & ~i_flush;
        end
      end

      always_ff @(posedge clk) begin
        r_exp[0] <= golden_sum(i_vec);
        for (int i = 1; i < LAT; i++) r_exp[i] <= r_exp[i-1];
`ifdef ADDR4U_BIST_FAIL_LOG_EN
        r_vec[0] <= i_vec;
        for (int i = 1; i < LAT; i++) r_vec[i] <= r_vec[i-1];
`endif
      end

      assign w_vld_al = r_vld[LAT-1];
      assign w_exp_al = r_exp[LAT-1];
`ifdef ADDR4U_BIST_FAIL_LOG_EN
      assign w_vec_al = r_vec[LAT-1];
`endif
    end
  endgenerate

  assign w_mis = w_vld_al && (i_dut_sum != w_exp_al);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else if (i_clr) begin
      r_err <= '0;
    end else if (w_mis && !(&r_err)) begin
      r_err <= r_err + ERR_W'(1);
    end
  end

  assign o_err_cnt = r_err;

`ifdef ADDR4U_BIST_FAIL_LOG_EN
  logic             r_ff_vld;
  logic [VEC_W-1:0] r_ff_vec;
  logic [SUMW-1:0]  r_ff_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff_vld <= 1'b0;
      r_ff_vec <= '0;
      r_ff_sum <= '0;
    end else if (i_clr) begin
      r_ff_vld <= 1'b0;
      r_ff_vec <= '0;
      r_ff_sum <= '0;
    end else if (w_mis && !r_ff_vld) begin
      r_ff_vld <= 1'b1;
      r_ff_vec <= w_vec_al;
      r_ff_sum <= i_dut_sum;
    end
  end

  assign o_first_fail_vld = r_ff_vld;
  assign o_first_fail_vec = r_ff_vec;
  assign o_first_fail_sum = r_ff_sum;
`endif

endmodule

// File: rtl/addr4u_bist_ctrl.sv
// Exhaustive 256-vector BIST sweep for a 4-bit adder: drives {A,B}, checks sums, reports pass/fail.
// Optional first-fail log ports exist only when ADDR4U_BIST_FAIL_LOG_EN is defined.
module addr4u_bist_ctrl
  import addr4u_bist_pkg::*;
#(
  parameter int LAT   = 0,
  parameter int ERR_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic [OPW-1:0]   o_pat_a,
  output logic [OPW-1:0]   o_pat_b,
  input  logic [SUMW-1:0]  i_dut_sum,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
`ifdef ADDR4U_BIST_FAIL_LOG_EN
  output logic             o_first_fail_vld,
  output logic [VEC_W-1:0] o_first_fail_vec,
  output logic [SUMW-1:0]  o_first_fail_sum,
`endif
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int               DRN_W    = (LAT < 2) ? 1 : $clog2(LAT);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((LAT > 0) ? LAT - 1 : 0);

  bist_state_t      r_state, w_state_nxt;
  logic [VEC_W-1:0] r_cnt;
  logic [DRN_W-1:0] r_drn;
  logic             w_run, w_start_acc, w_abort_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // abort outranks the end-of-sweep and end-of-drain transitions
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (i_start) w_state_nxt = RUN;
      RUN: begin
        if (i_abort)                 w_state_nxt = IDLE;
        else if (r_cnt == 8'hFF)     w_state_nxt = (LAT == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (i_abort)                 w_state_nxt = IDLE;
        else if (r_drn == DRN_LAST)  w_state_nxt = DONE;
      end
      DONE:  if (i_start) w_state_nxt = RUN;
      default:                       w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_run       = (r_state == RUN);
    o_busy      = (r_state == RUN) || (r_state == DRAIN);
    o_done      = (r_state == DONE);
    o_pass      = o_done && (o_err_cnt == '0);
    w_start_acc = i_start && ((r_state == IDLE) || (r_state == DONE));
    w_abort_acc = i_abort && o_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_drn <= '0;
    end else begin
      if (w_start_acc || w_abort_acc) r_cnt <= '0;
      else if (w_run)                 r_cnt <= r_cnt + VEC_W'(1);
      if (r_state == DRAIN)           r_drn <= r_drn + DRN_W'(1);
      else                            r_drn <= '0;
    end
  end

  assign o_pat_a = r_cnt[VEC_W-1:OPW];
  assign o_pat_b = r_cnt[OPW-1:0];

  addr4u_bist_cmp #(
    .LAT   (LAT),
    .ERR_W (ERR_W)
  ) u_cmp (
    .clk              (clk),
    .rst              (rst),
    .i_clr            (w_start_acc),
    .i_flush          (w_abort_acc),
    .i_vld            (w_run),
    .i_vec            (r_cnt),
    .i_dut_sum        (i_dut_sum),
`ifdef ADDR4U_BIST_FAIL_LOG_EN
    .o_first_fail_vld (o_first_fail_vld),
    .o_first_fail_vec (o_first_fail_vec),
    .o_first_fail_sum (o_first_fail_sum),
`endif
    .o_err_cnt        (o_err_cnt)
  );

endmodule
